// File: rtl/sargantana_icache_mem_ctrl.sv
// rtl/sargantana_icache_mem_ctrl.sv - icache tag/data memory sequencer for lookup, refill and flush
module sargantana_icache_mem_ctrl #(
    parameter int ICACHE_N_WAY = 4,
    parameter int ICACHE_DEPTH = 64,
    parameter int IDX_WIDTH    = 6,
    parameter int TAG_WIDTH    = 20,
    parameter int LINE_WIDTH   = 128
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    lookup_valid_i,
    input  logic [IDX_WIDTH-1:0]    lookup_idx_i,
    output logic                    lookup_ready_o,
    input  logic                    refill_valid_i,
    input  logic [IDX_WIDTH-1:0]    refill_idx_i,
    input  logic [TAG_WIDTH-1:0]    refill_tag_i,
    input  logic [LINE_WIDTH-1:0]   refill_line_i,
    output logic                    refill_ready_o,
    input  logic                    flush_req_i,
    output logic                    flush_busy_o,
    output logic                    flush_done_o,
    output logic                    rd_valid_o,
    output logic [ICACHE_N_WAY-1:0] tag_req_o,
    output logic [ICACHE_N_WAY-1:0] data_req_o,
    output logic                    tag_we_o,
    output logic                    data_we_o,
    output logic                    flush_en_o,
    output logic                    valid_bit_o,
    output logic [IDX_WIDTH-1:0]    addr_o,
    output logic [TAG_WIDTH-1:0]    tag_o,
    output logic [LINE_WIDTH-1:0]   cline_o,
    output logic [ICACHE_N_WAY-1:0] refill_way_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [IDX_WIDTH-1:0]    cnt_q;
    logic [ICACHE_N_WAY-1:0] victim_q;
    logic                    rd_valid_q;
    logic                    flush_done_q;

    logic in_idle;
    logic cnt_last;
    logic flush_acc;
    logic refill_acc;
    logic lookup_acc;

    assign in_idle    = (state_q == IDLE);
    assign cnt_last   = (cnt_q == IDX_WIDTH'(ICACHE_DEPTH - 1));
    assign refill_ready_o = in_idle && !rst_i && !flush_req_i;
    assign lookup_ready_o = refill_ready_o && !refill_valid_i;
    assign flush_acc  = in_idle && !rst_i && flush_req_i;
    assign refill_acc = refill_valid_i && refill_ready_o;
    assign lookup_acc = lookup_valid_i && lookup_ready_o;

    assign flush_busy_o = (state_q == FLUSH);
    assign flush_done_o = flush_done_q;
    assign rd_valid_o   = rd_valid_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (flush_req_i) state_d = FLUSH;
            FLUSH:   if (cnt_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Victim is kept one-hot and rotated so it maps straight onto the way enables.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q        <= '0;
            victim_q     <= ICACHE_N_WAY'(1);
            rd_valid_q   <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            rd_valid_q   <= lookup_acc;
            flush_done_q <= (state_q == FLUSH) && cnt_last;
            if (state_q == FLUSH) begin
                cnt_q <= cnt_last ? '0 : cnt_q + 1'b1;
            end else if (flush_acc) begin
                cnt_q <= '0;
            end
            if (refill_acc) begin
                victim_q <= (victim_q << 1) | (victim_q >> (ICACHE_N_WAY - 1));
            end
        end
    end

    always_comb begin
        tag_req_o    = '0;
        data_req_o   = '0;
        tag_we_o     = 1'b0;
        data_we_o    = 1'b0;
        flush_en_o   = 1'b0;
        valid_bit_o  = 1'b0;
        addr_o       = '0;
        tag_o        = '0;
        cline_o      = '0;
        refill_way_o = '0;
        case (state_q)
            FLUSH: begin
                tag_req_o  = '1;
                tag_we_o   = 1'b1;
                flush_en_o = 1'b1;
                addr_o     = cnt_q;
            end
            default: begin
                if (refill_acc) begin
                    tag_req_o    = victim_q;
                    data_req_o   = victim_q;
                    tag_we_o     = 1'b1;
                    data_we_o    = 1'b1;
                    valid_bit_o  = 1'b1;
                    addr_o       = refill_idx_i;
                    tag_o        = refill_tag_i;
                    cline_o      = refill_line_i;
                    refill_way_o = victim_q;
                end else if (lookup_acc) begin
                    tag_req_o  = '1;
                    data_req_o = '1;
                    addr_o     = lookup_idx_i;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_sargantana_icache_mem_ctrl.sv
// tb/tb_sargantana_icache_mem_ctrl.sv - self-checking bench for sargantana_icache_mem_ctrl
module tb_sargantana_icache_mem_ctrl;

    localparam int N  = 4;
    localparam int D  = 64;
    localparam int IW = 6;
    localparam int TW = 20;
    localparam int LW = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          lv;
    logic [IW-1:0] lidx;
    logic          lr;
    logic          rv;
    logic [IW-1:0] ridx;
    logic [TW-1:0] rtag;
    logic [LW-1:0] rline;
    logic          rr;
    logic          flush;
    logic          busy;
    logic          done;
    logic          rdv;
    logic [N-1:0]  treq;
    logic [N-1:0]  dreq;
    logic          twe;
    logic          dwe;
    logic          fen;
    logic          vb;
    logic [IW-1:0] addr;
    logic [TW-1:0] tag;
    logic [LW-1:0] cline;
    logic [N-1:0]  way;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sargantana_icache_mem_ctrl #(
        .ICACHE_N_WAY(N), .ICACHE_DEPTH(D), .IDX_WIDTH(IW), .TAG_WIDTH(TW), .LINE_WIDTH(LW)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .lookup_valid_i(lv), .lookup_idx_i(lidx), .lookup_ready_o(lr),
        .refill_valid_i(rv), .refill_idx_i(ridx), .refill_tag_i(rtag),
        .refill_line_i(rline), .refill_ready_o(rr),
        .flush_req_i(flush), .flush_busy_o(busy), .flush_done_o(done),
        .rd_valid_o(rdv), .tag_req_o(treq), .data_req_o(dreq),
        .tag_we_o(twe), .data_we_o(dwe), .flush_en_o(fen), .valid_bit_o(vb),
        .addr_o(addr), .tag_o(tag), .cline_o(cline), .refill_way_o(way)
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          lv;
        logic [IW-1:0] lidx;
        logic          rv;
        logic [IW-1:0] ridx;
        logic [TW-1:0] rtag;
        logic [LW-1:0] rline;
        logic          e_lr;
        logic          e_rr;
        logic [IW-1:0] e_addr;
        logic [N-1:0]  e_treq;
        logic [N-1:0]  e_dreq;
        logic          e_we;
        logic [TW-1:0] e_tag;
        logic [LW-1:0] e_line;
        logic [N-1:0]  e_way;
        logic          e_rdv;
    } vec_t;

    function automatic vec_t v_look(input logic [IW-1:0] idx, input logic e_rdv);
        vec_t v;
        v = '{lv: 1'b1, lidx: idx, rv: 1'b0, ridx: '0, rtag: '0, rline: '0,
              e_lr: 1'b1, e_rr: 1'b1, e_addr: idx, e_treq: 4'hF, e_dreq: 4'hF, e_we: 1'b0,
              e_tag: '0, e_line: '0, e_way: '0, e_rdv: e_rdv};
        return v;
    endfunction

    function automatic vec_t v_idle(input logic e_rdv);
        vec_t v;
        v = '{lv: 1'b0, lidx: '0, rv: 1'b0, ridx: '0, rtag: '0, rline: '0,
              e_lr: 1'b1, e_rr: 1'b1, e_addr: '0, e_treq: '0, e_dreq: '0, e_we: 1'b0,
              e_tag: '0, e_line: '0, e_way: '0, e_rdv: e_rdv};
        return v;
    endfunction

    function automatic vec_t v_ref(input logic [IW-1:0] idx, input logic [LW-1:0] line,
                                   input logic [N-1:0] w, input logic with_lookup);
        vec_t v;
        v = '{lv: with_lookup, lidx: 6'd9, rv: 1'b1, ridx: idx, rtag: 20'hABCDE, rline: line,
              e_lr: 1'b0, e_rr: 1'b1, e_addr: idx, e_treq: w, e_dreq: w, e_we: 1'b1,
              e_tag: 20'hABCDE, e_line: line, e_way: w, e_rdv: 1'b0};
        return v;
    endfunction

    task automatic drive(input logic r, input logic l_v, input logic [IW-1:0] l_i,
                         input logic r_v, input logic [IW-1:0] r_i, input logic [TW-1:0] r_t,
                         input logic [LW-1:0] r_l, input logic f);
        @(negedge clk);
        rst = r; lv = l_v; lidx = l_i; rv = r_v; ridx = r_i; rtag = r_t; rline = r_l; flush = f;
        #1;
    endtask

    // Reference model state (integer view of the controller)
    bit m_flush;
    int m_cnt;
    int m_vic;
    bit m_rdv;
    bit m_done;

    task automatic model_reset();
        m_flush = 0; m_cnt = 0; m_vic = 0; m_rdv = 0; m_done = 0;
    endtask

    task automatic model_check_and_step();
        bit            idle_ok;
        bit            e_rr, e_lr, acc_r, acc_l, acc_f;
        logic [N-1:0]  e_treq, e_dreq, e_way;
        logic          e_twe, e_dwe, e_fen, e_vb;
        logic [IW-1:0] e_addr;
        logic [TW-1:0] e_tag;
        logic [LW-1:0] e_line;
        idle_ok = !m_flush && !rst;
        e_rr  = idle_ok && !flush;
        e_lr  = e_rr && !rv;
        acc_f = idle_ok && flush;
        acc_r = e_rr && rv;
        acc_l = e_lr && lv;
        e_treq = '0; e_dreq = '0; e_way = '0; e_twe = 0; e_dwe = 0; e_fen = 0; e_vb = 0;
        e_addr = '0; e_tag = '0; e_line = '0;
        if (m_flush) begin
            e_treq = '1; e_twe = 1; e_fen = 1; e_addr = IW'(m_cnt);
        end else if (acc_r) begin
            e_way = N'(1 << m_vic);
            e_treq = e_way; e_dreq = e_way; e_twe = 1; e_dwe = 1; e_vb = 1;
            e_addr = ridx; e_tag = rtag; e_line = rline;
        end else if (acc_l) begin
            e_treq = '1; e_dreq = '1; e_addr = lidx;
        end
        chk("rnd_ready", {lr, rr}, {e_lr, e_rr});
        chk("rnd_status", {busy, done, rdv}, {m_flush, m_done, m_rdv});
        chk("rnd_ctl", {treq, dreq, twe, dwe, fen, vb, way}, {e_treq, e_dreq, e_twe, e_dwe, e_fen, e_vb, e_way});
        chk("rnd_addr_tag", {addr, tag}, {e_addr, e_tag});
        chk("rnd_line", cline, e_line);
        if (rst) begin
            model_reset();
        end else begin
            m_rdv  = acc_l;
            m_done = m_flush && (m_cnt == D - 1);
            if (m_flush) begin
                if (m_cnt == D - 1) begin m_flush = 0; m_cnt = 0; end
                else m_cnt = m_cnt + 1;
            end else if (acc_f) begin
                m_flush = 1; m_cnt = 0;
            end
            if (acc_r) m_vic = (m_vic + 1) % N;
        end
    endtask

    vec_t tbl[10];

    initial begin
        logic [LW-1:0] ln;
        int            pulses;
        ln = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        tbl[0] = v_look(6'd5, 1'b0);
        tbl[1] = v_idle(1'b1);
        tbl[2] = v_ref(6'd3, ln, 4'b0001, 1'b0);
        tbl[3] = v_ref(6'd3, ~ln, 4'b0010, 1'b0);
        tbl[4] = v_ref(6'd3, ln, 4'b0100, 1'b0);
        tbl[5] = v_ref(6'd3, ~ln, 4'b1000, 1'b0);
        tbl[6] = v_ref(6'd3, ln, 4'b0001, 1'b0);
        tbl[7] = v_ref(6'd3, ~ln, 4'b0010, 1'b1);
        tbl[8] = v_look(6'd9, 1'b0);
        tbl[9] = v_idle(1'b1);

        rst = 1; lv = 0; lidx = '0; rv = 0; ridx = '0; rtag = '0; rline = '0; flush = 0;
        drive(1, 1, 6'd1, 1, 6'd2, '0, '0, 0);
        chk("ready_in_reset", {lr, rr}, 2'b00);
        drive(1, 0, '0, 0, '0, '0, '0, 0);
        drive(0, 0, '0, 0, '0, '0, '0, 0);
        chk("reset_status", {busy, done, rdv}, 3'b000);
        chk("reset_mem_idle", {treq, dreq, twe, dwe, fen, vb, addr, way}, '0);

        for (int i = 0; i < 10; i++) begin
            drive(0, tbl[i].lv, tbl[i].lidx, tbl[i].rv, tbl[i].ridx, tbl[i].rtag, tbl[i].rline, 0);
            chk($sformatf("vec%0d_ready", i), {lr, rr}, {tbl[i].e_lr, tbl[i].e_rr});
            chk($sformatf("vec%0d_req", i), {addr, treq, dreq, way}, {tbl[i].e_addr, tbl[i].e_treq, tbl[i].e_dreq, tbl[i].e_way});
            chk($sformatf("vec%0d_we", i), {twe, dwe, vb, fen}, {tbl[i].e_we, tbl[i].e_we, tbl[i].e_we, 1'b0});
            chk($sformatf("vec%0d_data", i), {tag, cline}, {tbl[i].e_tag, tbl[i].e_line});
            chk($sformatf("vec%0d_rdv", i), rdv, tbl[i].e_rdv);
        end

        // Flush walk with competing requests; victim is now way 2.
        drive(0, 1, 6'd4, 1, 6'd4, 20'h1, '0, 1);
        chk("flush_entry_ready", {lr, rr, twe, busy}, 4'b0000);
        for (int i = 0; i < D; i++) begin
            drive(0, 1, 6'd4, 1, 6'd4, 20'h1, '0, i < 5);
            chk($sformatf("flush%0d", i), {busy, done, lr, rr, addr, treq, dreq, twe, dwe, fen, vb},
                {1'b1, 1'b0, 1'b0, 1'b0, IW'(i), 4'hF, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0});
        end
        drive(0, 1, 6'd7, 0, '0, '0, '0, 0);
        chk("flush_done_pulse", {done, busy, lr, addr, treq}, {1'b1, 1'b0, 1'b1, 6'd7, 4'hF});
        drive(0, 1, 6'd8, 1, 6'd8, 20'h5, '0, 0);
        chk("after_flush", {done, rdv, rr, way}, {1'b0, 1'b1, 1'b1, 4'b0100});

        // Reset at flush counter 20; victim is now way 3.
        drive(0, 0, '0, 0, '0, '0, '0, 1);
        for (int i = 0; i < 20; i++) drive(0, 0, '0, 0, '0, '0, '0, 0);
        drive(1, 1, '0, 1, '0, '0, '0, 0);
        chk("rst_mid_flush", {addr, busy, lr, rr}, {6'd20, 1'b1, 1'b0, 1'b0});
        pulses = 0;
        for (int i = 0; i < 70; i++) begin
            drive(0, 0, '0, 0, '0, '0, '0, 0);
            if (i == 0) chk("rst_abort_idle", {busy, done}, 2'b00);
            if (done) pulses++;
        end
        chk("rst_no_done", pulses, 0);
        drive(0, 0, '0, 1, 6'd2, 20'h7, '0, 0);
        chk("rst_victim_way0", way, 4'b0001);

        // Randomized run against the reference model
        drive(1, 0, '0, 0, '0, '0, '0, 0);
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 1), IW'($urandom),
                  $urandom_range(0, 2) == 0, IW'($urandom), TW'($urandom),
                  {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 39) == 0);
            model_check_and_step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sargantana_icache_mem_ctrl.md
SARGANTANA_ICACHE_MEM_CTRL -- requirements
Module: sargantana_icache_mem_ctrl

Interface
REQ-001 Parameter ICACHE_N_WAY, default 4, number of ways.
REQ-002 Parameter ICACHE_DEPTH, default 64, sets per way; power of two, at least 2.
REQ-003 Parameter IDX_WIDTH, default 6, equals log2(ICACHE_DEPTH).
REQ-004 Parameter TAG_WIDTH, default 20, tag width.
REQ-005 Parameter LINE_WIDTH, default 128, cache line width.
REQ-006 Port clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-007 Port rst_i  in  1  reset; synchronous, active-high.
REQ-008 Port lookup_valid_i  in  1  fetch read request.
REQ-009 Port lookup_idx_i  in  IDX_WIDTH  set index to read.
REQ-010 Port lookup_ready_o  out  1  lookup accepted this cycle when high together with lookup_valid_i.
REQ-011 Port refill_valid_i  in  1  refill write request.
REQ-012 Port refill_idx_i  in  IDX_WIDTH  set index to fill.
REQ-013 Port refill_tag_i  in  TAG_WIDTH  tag to write.
REQ-014 Port refill_line_i  in  LINE_WIDTH  line to write.
REQ-015 Port refill_ready_o  out  1  refill accepted when high together with refill_valid_i.
REQ-016 Port flush_req_i  in  1  invalidate-all request.
REQ-017 Port flush_busy_o  out  1  high while in state FLUSH.
REQ-018 Port flush_done_o  out  1  one-cycle completion pulse.
REQ-019 Port rd_valid_o  out  1  pulses one cycle after an accepted lookup, aligned with the memory read data.
REQ-020 Port tag_req_o  out  ICACHE_N_WAY  per-way tag memory enable.
REQ-021 Port data_req_o  out  ICACHE_N_WAY  per-way data memory enable.
REQ-022 Port tag_we_o  out  1  tag/valid write enable.
REQ-023 Port data_we_o  out  1  data write enable.
REQ-024 Port flush_en_o  out  1  flush qualifier to the tag memory.
REQ-025 Port valid_bit_o  out  1  valid bit to write.
REQ-026 Port addr_o  out  IDX_WIDTH  set index to the memories.
REQ-027 Port tag_o  out  TAG_WIDTH  tag to write.
REQ-028 Port cline_o  out  LINE_WIDTH  line to write.
REQ-029 Port refill_way_o  out  ICACHE_N_WAY  one-hot victim way of the current refill; zero otherwise.

Function
REQ-030 The FSM shall have two states, IDLE and FLUSH, held in a register.
REQ-031 Priority in IDLE shall be flush, then refill, then lookup.
REQ-032 In IDLE with flush_req_i high, the block shall enter FLUSH next cycle with the set counter at 0; refill_ready_o and lookup_ready_o shall be 0 that cycle.
REQ-033 In IDLE, refill_ready_o shall equal !flush_req_i.
REQ-034 In IDLE, lookup_ready_o shall equal !flush_req_i && !refill_valid_i.
REQ-035 Both ready outputs shall be 0 in FLUSH.
REQ-036 On an accepted lookup, the block shall drive, combinationally in the same cycle: tag_req_o and data_req_o all-ones; tag_we_o, data_we_o and flush_en_o 0; addr_o equal to lookup_idx_i.
REQ-037 On an accepted refill, the block shall drive, combinationally in the same cycle: tag_req_o and data_req_o equal to the victim one-hot; tag_we_o, data_we_o and valid_bit_o 1; addr_o equal to refill_idx_i; tag_o equal to refill_tag_i; cline_o equal to refill_line_i.
REQ-038 The victim pointer shall be a round-robin register, reset to way 0, advanced by one per accepted refill, wrapping from ICACHE_N_WAY-1 to 0.
REQ-039 In FLUSH, every cycle the block shall drive: tag_req_o all-ones; data_req_o 0; tag_we_o and flush_en_o 1; valid_bit_o 0; addr_o equal to the counter.
REQ-040 In FLUSH, the counter shall increment by one each cycle.
REQ-041 When the counter equals ICACHE_DEPTH-1, the block shall return to IDLE and pulse flush_done_o the following cycle; a flush therefore occupies exactly ICACHE_DEPTH cycles.
REQ-042 flush_req_i shall be ignored while in FLUSH, with no queueing.
REQ-043 rd_valid_o shall be registered: high exactly one cycle after each accepted lookup, otherwise 0.
REQ-044 With no accepted operation and not in FLUSH, all memory-side outputs shall be 0.
REQ-045 The block shall accept lookups and refills in the cycle flush_done_o is high.

Reset
REQ-046 With rst_i high at a clock edge, the next state shall be: state IDLE, counter 0, victim way 0, rd_valid_o 0, flush_done_o 0.
REQ-047 Reset during FLUSH shall abort the walk with no flush_done_o pulse.
REQ-048 While rst_i is high, both ready outputs shall be 0.

Verification
REQ-049 Reset, then lookup idx 5 -> same cycle: addr_o=5, tag_req_o=data_req_o=4'b1111, no write enables; next cycle rd_valid_o=1.
REQ-050 Five refills, idx 3, tag 0xABCDE -> refill_way_o sequence 0001, 0010, 0100, 1000, 0001, each with tag_we_o=data_we_o=valid_bit_o=1.
REQ-051 Same-cycle refill and lookup -> refill accepted, lookup_ready_o=0; lookup accepted in the next cycle.
REQ-052 flush_req_i pulse -> flush_busy_o high for 64 cycles with addr_o stepping 0..63 and valid_bit_o=0; flush_done_o=1 on cycle 65; requests during the walk are not accepted.
REQ-053 rst_i asserted at flush counter 20 -> next cycle IDLE, flush_busy_o=0, flush_done_o never pulses, victim way returns to 0.
